// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared constants and helpers for the FPU issue/retire controller.
// fflags bit order is {NV,DZ,OF,UF,NX}, NV at bit 4 down to NX at bit 0.
package fpu_issue_ctrl_pkg;

    localparam int DEF_NUM_WARPS = 4;
    localparam int DEF_NW_BITS   = 2;
    localparam int FFLAGS_W      = 5;

    // A clear and a same-cycle accrual keep the newly accrued flags.
    function automatic logic [FFLAGS_W-1:0] fflags_next(
        input logic [FFLAGS_W-1:0] cur,
        input logic                clr,
        input logic                acc_en,
        input logic [FFLAGS_W-1:0] acc
    );
        logic [FFLAGS_W-1:0] base;
        base = clr ? {FFLAGS_W{1'b0}} : cur;
        return base | (acc_en ? acc : {FFLAGS_W{1'b0}});
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_chk.sv
// Protocol checker: a result must never return for a tag that is already free.
module fpu_issue_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic retire_fire,
    input logic release_free
);

    a_retire_busy_tag: assert property (@(posedge clk) disable iff (reset)
        retire_fire |-> !release_free);

endmodule

// File: rtl/fpu_tag_table.sv
// Tag allocator: free mask, lowest-free priority encoder and per-tag
// writeback metadata with one alloc write port and one async read port.
module fpu_tag_table
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int TAGW    = 2,
    parameter int NW_BITS = DEF_NW_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_en,
    input  logic [NW_BITS-1:0] alloc_wid,
    input  logic [4:0]         alloc_rd,
    input  logic               alloc_wb,
    input  logic               release_en,
    input  logic [TAGW-1:0]    release_tag,
    output logic [TAGW-1:0]    alloc_tag,
    output logic               full,
    output logic [NW_BITS-1:0] read_wid,
    output logic [4:0]         read_rd,
    output logic               read_wb,
    output logic               release_free
);

    localparam int DEPTH = 1 << TAGW;

    logic [DEPTH-1:0]   free_r;
    logic [NW_BITS-1:0] wid_r [DEPTH];
    logic [4:0]         rd_r  [DEPTH];
    logic [DEPTH-1:0]   wb_r;

    // Lowest-index free tag; scanning downward lets the lowest index win.
    always_comb begin
        alloc_tag = {TAGW{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            alloc_tag = free_r[i] ? TAGW'(i) : alloc_tag;
        end
    end

    assign full         = ~|free_r;
    assign read_wid     = wid_r[release_tag];
    assign read_rd      = rd_r[release_tag];
    assign read_wb      = wb_r[release_tag];
    assign release_free = free_r[release_tag];

    // Free mask: the released tag only becomes visible to the encoder next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_r <= {DEPTH{1'b1}};
        end else begin
            if (alloc_en) begin
                free_r[alloc_tag] <= 1'b0;
            end
            if (release_en) begin
                free_r[release_tag] <= 1'b1;
            end
        end
    end

    // Metadata store; contents are meaningless while a tag is free, so no reset.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            wid_r[alloc_tag] <= alloc_wid;
            rd_r[alloc_tag]  <= alloc_rd;
            wb_r[alloc_tag]  <= alloc_wb;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/retire controller in front of the FPU wrapper: tag allocation,
// per-warp in-flight counters and per-warp sticky fflags.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int TAGW      = 2,
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int NW_BITS   = DEF_NW_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NW_BITS-1:0]     req_wid,
    input  logic [4:0]             req_rd,
    input  logic                   req_wb,
    output logic                   fpu_valid_in,
    input  logic                   fpu_ready_in,
    output logic [TAGW-1:0]        fpu_tag_in,
    input  logic                   fpu_valid_out,
    output logic                   fpu_ready_out,
    input  logic [TAGW-1:0]        fpu_tag_out,
    input  logic                   fpu_has_fflags,
    input  logic [4:0]             fpu_fflags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NW_BITS-1:0]     rsp_wid,
    output logic [4:0]             rsp_rd,
    output logic                   rsp_wb,
    input  logic                   csr_clear_valid,
    input  logic [NW_BITS-1:0]     csr_clear_wid,
    output logic [NUM_WARPS*5-1:0] fflags,
    output logic [NUM_WARPS-1:0]   pending
);

    logic                 full_s;
    logic [TAGW-1:0]      alloc_tag_s;
    logic                 issue_fire_s;
    logic                 retire_fire_s;
    logic                 release_free_s;
    logic [NUM_WARPS-1:0] inc_s;
    logic [NUM_WARPS-1:0] dec_s;
    logic [TAGW:0]        cnt_r     [NUM_WARPS];
    logic [TAGW:0]        cnt_nxt_s [NUM_WARPS];
    logic [4:0]           ff_r      [NUM_WARPS];
    logic [4:0]           ff_nxt_s  [NUM_WARPS];

    assign fpu_valid_in  = req_valid & ~full_s;
    assign req_ready     = fpu_ready_in & ~full_s;
    assign fpu_tag_in    = alloc_tag_s;
    assign issue_fire_s  = req_valid & req_ready;
    assign rsp_valid     = fpu_valid_out;
    assign fpu_ready_out = rsp_ready;
    assign retire_fire_s = fpu_valid_out & rsp_ready;

    fpu_tag_table #(
        .TAGW    (TAGW),
        .NW_BITS (NW_BITS)
    ) u_tag_table (
        .clk          (clk),
        .reset        (reset),
        .alloc_en     (issue_fire_s),
        .alloc_wid    (req_wid),
        .alloc_rd     (req_rd),
        .alloc_wb     (req_wb),
        .release_en   (retire_fire_s),
        .release_tag  (fpu_tag_out),
        .alloc_tag    (alloc_tag_s),
        .full         (full_s),
        .read_wid     (rsp_wid),
        .read_rd      (rsp_rd),
        .read_wb      (rsp_wb),
        .release_free (release_free_s)
    );

    fpu_issue_ctrl_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .retire_fire  (retire_fire_s),
        .release_free (release_free_s)
    );

    // Per-warp issue/retire strobes.
    always_comb begin
        inc_s = {NUM_WARPS{1'b0}};
        dec_s = {NUM_WARPS{1'b0}};
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc_s[w] = issue_fire_s  && (req_wid == NW_BITS'(w));
            dec_s[w] = retire_fire_s && (rsp_wid == NW_BITS'(w));
        end
    end

    // Next in-flight count and sticky flags per warp.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_nxt_s[w] = cnt_r[w];
            case ({inc_s[w], dec_s[w]})
                2'b10:   cnt_nxt_s[w] = cnt_r[w] + {{TAGW{1'b0}}, 1'b1};
                2'b01:   cnt_nxt_s[w] = cnt_r[w] - {{TAGW{1'b0}}, 1'b1};
                default: cnt_nxt_s[w] = cnt_r[w];
            endcase
            ff_nxt_s[w] = fflags_next(ff_r[w],
                                      csr_clear_valid && (csr_clear_wid == NW_BITS'(w)),
                                      dec_s[w] && fpu_has_fflags,
                                      fpu_fflags);
        end
    end

    // Per-warp state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= {(TAGW + 1){1'b0}};
                ff_r[w]  <= 5'b00000;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= cnt_nxt_s[w];
                ff_r[w]  <= ff_nxt_s[w];
            end
        end
    end

    // Flatten per-warp state onto the status outputs.
    always_comb begin
        fflags  = {(NUM_WARPS * 5){1'b0}};
        pending = {NUM_WARPS{1'b0}};
        for (int w = 0; w < NUM_WARPS; w++) begin
            fflags[5*w +: 5] = ff_r[w];
            pending[w]       = (cnt_r[w] != {(TAGW + 1){1'b0}});
        end
    end

endmodule
